periph_bridge_xbar: RTL and testbench
=====================================

Name: periph_bridge_xbar

Overview:
- Parametrised next-generation peripheral subsystem front end: a single OBI slave port bridged to NPORTS register-bus master ports through an internal address decoder.
- Adds behaviour the previous subsystem lacked: runtime address map, decode-error responses for unmapped addresses, a per-access ready timeout, and back-to-back grants.
- Sits between the system crossbar peripheral slave port and the peripheral blocks (boot ROM, timers, control registers).

Parameters:
- NPORTS, 4, number of register-bus master ports (1..16).
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- TIMEOUT_CYCLES, 256, cycles to wait for reg_ready_i before an error response; 0 disables the timeout.
- ERR_RDATA, 32'hBADC_AB1E, rdata returned on any error response.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- obi_req_i  in  1  OBI request.
- obi_gnt_o  out  1  OBI grant.
- obi_addr_i  in  AW  OBI address.
- obi_we_i  in  1  1 = write.
- obi_be_i  in  DW/8  byte enables.
- obi_wdata_i  in  DW  write data.
- obi_rvalid_o  out  1  response valid.
- obi_rdata_o  out  DW  read data.
- obi_err_o  out  1  error response.
- map_base_i  in  NPORTS*AW  per-port region start, inclusive.
- map_end_i  in  NPORTS*AW  per-port region end, exclusive.
- reg_valid_o  out  NPORTS  one-hot valid per port.
- reg_addr_o  out  AW  shared address, full and unmodified.
- reg_write_o  out  1  shared write flag.
- reg_wdata_o  out  DW  shared write data.
- reg_wstrb_o  out  DW/8  shared byte strobes.
- reg_rdata_i  in  NPORTS*DW  per-port read data.
- reg_error_i  in  NPORTS  per-port error.
- reg_ready_i  in  NPORTS  per-port ready.
- err_count_o  out  16  error counter (optional feature).

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Values while rst_i is high: state IDLE; all outputs 0; latched request fields 0; timeout counter 0; err_count_o 0.
- FSM states:
  - IDLE: obi_gnt_o = obi_req_i, combinational. On req&gnt, latch addr/we/be/wdata and decode. Hit goes to ACCESS; miss goes to RESP with err=1.
  - ACCESS: reg_valid_o[sel]=1 and the shared fields are driven from the latches. obi_gnt_o=0.
    - On reg_ready_i[sel]: capture reg_rdata_i[sel] and reg_error_i[sel], then go to RESP.
    - Otherwise, once the counter reaches TIMEOUT_CYCLES-1 (nonzero param), go to RESP with err=1.
  - RESP: obi_rvalid_o=1 for exactly one cycle.
    - obi_err_o is the captured error. obi_rdata_o is the captured rdata on a successful read, ERR_RDATA on any error, and 0 on a successful write.
    - obi_gnt_o = obi_req_i here as well, giving back-to-back operation. An accepted request is decoded and goes to ACCESS or RESP(miss). With no request, go to IDLE.
- Decode:
  - Port i hits when base_i <= addr < end_i (unsigned AW-bit compare).
  - Regions with base >= end never hit.
  - Overlapping regions: the lowest index wins.
  - Decode is sampled at grant; later changes to map_*_i do not affect an in-flight access.
- Latency: granted hit with ready in its first ACCESS cycle gives rvalid 2 cycles after grant. Decode miss gives rvalid 1 cycle after grant.
- Timeout:
  - The counter increments each ACCESS cycle without ready and clears on entry to ACCESS.
  - Ready in the same cycle as the timeout takes priority (normal response).
  - Timeout counts as an error.
- Only one access is outstanding at a time. reg_valid_o is never asserted on more than one port. reg_valid_o stays high until ready or timeout.
- Reset mid-access: after the reset edge, reg_valid_o=0; no response is ever issued for the aborted access.

Optional Feature:
- Macro: PERIPH_BRIDGE_ERR_COUNT_EN.
- Defined: err_count_o increments by 1 on every RESP cycle with obi_err_o=1. It saturates at 16'hFFFF and clears only on reset.
- Not defined: err_count_o is tied to 0 and no counter flops are inferred.

Test Plan:
- Map port0=[0x2000_0000,0x2000_1000). Read 0x2000_0010, port0 ready in 1st cycle with rdata 0x1234_5678 -> rvalid 2 cycles after gnt, rdata 0x1234_5678, err 0.
- Write 0x3000_0000, unmapped -> reg_valid_o stays 0; rvalid 1 cycle after gnt; err 1; rdata 0xBADC_AB1E; err_count_o=1 when macro defined.
- TIMEOUT_CYCLES=8, port1 never ready -> reg_valid_o[1] high for 8 cycles, then rvalid with err 1. Repeat with ready in cycle 8 -> err 0.
- Overlapping maps port0/port2 both cover 0x4000_0000 -> only reg_valid_o[0] asserted.
- obi_req_i held high for 3 reads with immediate ready -> gnt in IDLE then in each RESP cycle; 3 rvalids in 6 cycles.
- rst_i asserted during ACCESS -> next cycle all outputs 0, no rvalid; next request served normally.

Source files
------------

// File: rtl/periph_bridge_xbar.sv
// OBI slave bridged to NPORTS register-bus masters through a runtime address map,
// with decode-error and ready-timeout responses. Optional error counter: PERIPH_BRIDGE_ERR_COUNT_EN.
module periph_bridge_xbar #(
  parameter int              NPORTS         = 4,
  parameter int              AW             = 32,
  parameter int              DW             = 32,
  parameter int              TIMEOUT_CYCLES = 256,
  parameter logic [DW-1:0]   ERR_RDATA      = DW'(32'hBADC_AB1E)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 obi_req_i,
  output logic                 obi_gnt_o,
  input  logic [AW-1:0]        obi_addr_i,
  input  logic                 obi_we_i,
  input  logic [DW/8-1:0]      obi_be_i,
  input  logic [DW-1:0]        obi_wdata_i,
  output logic                 obi_rvalid_o,
  output logic [DW-1:0]        obi_rdata_o,
  output logic                 obi_err_o,
  input  logic [NPORTS*AW-1:0] map_base_i,
  input  logic [NPORTS*AW-1:0] map_end_i,
  output logic [NPORTS-1:0]    reg_valid_o,
  output logic [AW-1:0]        reg_addr_o,
  output logic                 reg_write_o,
  output logic [DW-1:0]        reg_wdata_o,
  output logic [DW/8-1:0]      reg_wstrb_o,
  input  logic [NPORTS*DW-1:0] reg_rdata_i,
  input  logic [NPORTS-1:0]    reg_error_i,
  input  logic [NPORTS-1:0]    reg_ready_i,
  output logic [15:0]          err_count_o
);

  // state  | meaning
  // IDLE   | nothing outstanding; grant follows request
  // ACCESS | reg_valid_o held on the selected port until ready or timeout
  // RESP   | single-cycle OBI response; may accept the next request

  localparam int SW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int BW = DW / 8;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [BW-1:0]   be_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   sel_q;
  logic            rsp_err_q;
  logic [DW-1:0]   rsp_rdata_q;

  logic            accept;
  logic            dec_hit;
  logic [SW-1:0]   dec_sel;
  logic            sel_ready;
  logic            sel_error;
  logic [DW-1:0]   sel_rdata;
  logic            tmo_hit;
  logic            in_access;
  logic            in_resp;

  assign accept    = obi_req_i && !rst_i && ((state_q == IDLE) || (state_q == RESP));
  assign in_access = (state_q == ACCESS) && !rst_i;
  assign in_resp   = (state_q == RESP) && !rst_i;

  // Walk from the top index down so the lowest matching port is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if ((map_base_i[i*AW +: AW] <= obi_addr_i) && (obi_addr_i < map_end_i[i*AW +: AW])) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  assign sel_ready = reg_ready_i[sel_q];
  assign sel_error = reg_error_i[sel_q];
  assign sel_rdata = reg_rdata_i[sel_q*DW +: DW];

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      // Down-counter loaded at grant; terminal count means the access has run its full budget.
      logic [TW-1:0] tmo_cnt_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          tmo_cnt_q <= '0;
        end else if (accept) begin
          tmo_cnt_q <= TW'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == ACCESS) && (tmo_cnt_q != '0)) begin
          tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
      end

      assign tmo_hit = (state_q == ACCESS) && (tmo_cnt_q == '0);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = dec_hit ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (sel_ready || tmo_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (accept) begin
          state_d = dec_hit ? ACCESS : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (accept) begin
      addr_q      <= obi_addr_i;
      we_q        <= obi_we_i;
      be_q        <= obi_be_i;
      wdata_q     <= obi_wdata_i;
      sel_q       <= dec_sel;
      rsp_err_q   <= !dec_hit;
      rsp_rdata_q <= '0;
    end else if (state_q == ACCESS) begin
      // Ready wins over a timeout landing in the same cycle.
      if (sel_ready) begin
        rsp_err_q   <= sel_error;
        rsp_rdata_q <= sel_rdata;
      end else if (tmo_hit) begin
        rsp_err_q   <= 1'b1;
      end
    end
  end

  assign obi_gnt_o    = accept;
  assign obi_rvalid_o = in_resp;
  assign obi_err_o    = in_resp && rsp_err_q;

  always_comb begin
    obi_rdata_o = '0;
    if (in_resp) begin
      if (rsp_err_q) begin
        obi_rdata_o = ERR_RDATA;
      end else if (!we_q) begin
        obi_rdata_o = rsp_rdata_q;
      end
    end
  end

  always_comb begin
    reg_valid_o = '0;
    if (in_access) begin
      reg_valid_o[sel_q] = 1'b1;
    end
  end

  assign reg_addr_o  = in_access ? addr_q  : '0;
  assign reg_write_o = in_access && we_q;
  assign reg_wdata_o = in_access ? wdata_q : '0;
  assign reg_wstrb_o = in_access ? be_q    : '0;

`ifdef PERIPH_BRIDGE_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (obi_err_o && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count_o = err_cnt_q;
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_periph_bridge_xbar.sv
// Self-checking bench for periph_bridge_xbar: table vectors, randomized maps/accesses
// against a transaction-level model, and hand-written back-to-back and reset sequences.
module tb_periph_bridge_xbar;
  localparam int NP  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam logic [31:0] ERRV = 32'hBADC_AB1E;

  logic              clk = 1'b0;
  logic              rst;
  logic              obi_req;
  logic              obi_gnt;
  logic [AW-1:0]     obi_addr;
  logic              obi_we;
  logic [DW/8-1:0]   obi_be;
  logic [DW-1:0]     obi_wdata;
  logic              obi_rvalid;
  logic [DW-1:0]     obi_rdata;
  logic              obi_err;
  logic [NP*AW-1:0]  map_base;
  logic [NP*AW-1:0]  map_end;
  logic [NP-1:0]     reg_valid;
  logic [AW-1:0]     reg_addr;
  logic              reg_write;
  logic [DW-1:0]     reg_wdata;
  logic [DW/8-1:0]   reg_wstrb;
  logic [NP*DW-1:0]  reg_rdata;
  logic [NP-1:0]     reg_error;
  logic [NP-1:0]     reg_ready;
  logic [15:0]       err_count;

  logic [AW-1:0]     base_a [NP];
  logic [AW-1:0]     end_a  [NP];

  int total = 0;
  int bad   = 0;
  int exp_err_cnt = 0;

  always #5 clk = ~clk;

  always_comb begin
    map_base = '0;
    map_end  = '0;
    for (int i = 0; i < NP; i++) begin
      map_base[i*AW +: AW] = base_a[i];
      map_end[i*AW +: AW]  = end_a[i];
    end
  end

  periph_bridge_xbar #(
    .NPORTS(NP), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERRV)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr), .obi_we_i(obi_we),
    .obi_be_i(obi_be), .obi_wdata_i(obi_wdata), .obi_rvalid_o(obi_rvalid),
    .obi_rdata_o(obi_rdata), .obi_err_o(obi_err),
    .map_base_i(map_base), .map_end_i(map_end),
    .reg_valid_o(reg_valid), .reg_addr_o(reg_addr), .reg_write_o(reg_write),
    .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb), .reg_rdata_i(reg_rdata),
    .reg_error_i(reg_error), .reg_ready_i(reg_ready), .err_count_o(err_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: first matching region wins; latency counted in
  // cycles after the grant cycle.
  function automatic void model(input logic [31:0] addr, input logic we, input int lat,
                                input logic perr, input logic [31:0] prd,
                                output logic hit, output int sel, output logic err,
                                output logic [31:0] rd, output int k);
    hit = 1'b0;
    sel = 0;
    for (int i = 0; i < NP; i++) begin
      if (!hit && base_a[i] <= addr && addr < end_a[i]) begin
        hit = 1'b1;
        sel = i;
      end
    end
    if (!hit) begin
      err = 1'b1; k = 1;
    end else if (lat <= TMO) begin
      err = perr; k = lat + 1;
    end else begin
      err = 1'b1; k = TMO + 1;
    end
    rd = err ? ERRV : (we ? 32'h0 : prd);
  endfunction

  task automatic set_fixed_map();
    base_a[0] = 32'h2000_0000; end_a[0] = 32'h2000_1000;
    base_a[1] = 32'h2000_1000; end_a[1] = 32'h2000_2000;
    base_a[2] = 32'h4000_0000; end_a[2] = 32'h4001_0000;
    base_a[3] = 32'h5000_0000; end_a[3] = 32'h5000_0000;
  endtask

  task automatic run_txn(input string nm, input logic [31:0] addr, input logic we,
                         input int lat, input logic perr, input logic [31:0] prd,
                         input logic scramble, input logic e_hit, input int e_sel,
                         input logic e_err, input logic [31:0] e_rd, input int e_k);
    logic        seen;
    logic [3:0]  be;
    logic [31:0] wd;
    be = 4'($urandom);
    wd = $urandom;
    @(negedge clk);
    obi_req = 1'b1; obi_addr = addr; obi_we = we; obi_be = be; obi_wdata = wd;
    reg_ready = '0;
    #1 chk({nm, " gnt"}, 64'(obi_gnt), 64'd1);
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      obi_req = 1'b0; obi_addr = $urandom; obi_we = 1'($urandom); obi_be = 4'($urandom);
      obi_wdata = $urandom;
      if (scramble && k == 1) begin
        for (int i = 0; i < NP; i++) begin base_a[i] = '0; end_a[i] = '0; end
      end
      for (int i = 0; i < NP; i++) begin
        reg_rdata[i*DW +: DW] = $urandom;
        reg_error[i] = 1'($urandom);
        reg_ready[i] = 1'($urandom);
      end
      if (e_hit) begin
        reg_ready[e_sel] = (k == lat);
        reg_error[e_sel] = perr;
        reg_rdata[e_sel*DW +: DW] = prd;
      end
      #1;
      if (obi_rvalid) begin
        seen = 1'b1;
        chk({nm, " latency"}, 64'(k), 64'(e_k));
        chk({nm, " err"}, 64'(obi_err), 64'(e_err));
        chk({nm, " rdata"}, 64'(obi_rdata), 64'(e_rd));
        chk({nm, " valid_in_resp"}, 64'(reg_valid), 64'd0);
      end else begin
        chk({nm, " valid"}, 64'(reg_valid), e_hit ? (64'd1 << e_sel) : 64'd0);
        if (k == 1 && e_hit) begin
          chk({nm, " reg_addr"}, 64'(reg_addr), 64'(addr));
          chk({nm, " reg_write"}, 64'(reg_write), 64'(we));
          chk({nm, " reg_wdata"}, 64'(reg_wdata), 64'(wd));
          chk({nm, " reg_wstrb"}, 64'(reg_wstrb), 64'(be));
        end
      end
    end
    if (!seen) chk({nm, " rvalid_arrived"}, 64'd0, 64'd1);
    @(negedge clk);
    reg_ready = '0;
    #1 chk({nm, " single_rvalid"}, 64'(obi_rvalid), 64'd0);
    if (e_err) exp_err_cnt++;
  endtask

  typedef struct {
    logic [31:0] addr; logic we; int lat; logic perr; logic [31:0] prd;
    logic e_hit; int e_sel; logic e_err; logic [31:0] e_rd; int e_k;
  } vec_t;

  vec_t vt[10];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hit, err;
    int          sel, k, lat, nrv;
    logic [31:0] rd, addr, prd;
    logic        we, perr;
    logic        e_gnt[7];
    logic        e_rv[7];

    vt[0] = '{32'h2000_0010, 1'b0, 1,  1'b0, 32'h1234_5678, 1'b1, 0, 1'b0, 32'h1234_5678, 2};
    vt[1] = '{32'h3000_0000, 1'b1, 1,  1'b0, 32'h0,         1'b0, 0, 1'b1, ERRV,          1};
    vt[2] = '{32'h2000_1004, 1'b0, 99, 1'b0, 32'h7777_7777, 1'b1, 1, 1'b1, ERRV,          9};
    vt[3] = '{32'h2000_1008, 1'b0, 8,  1'b0, 32'hCAFE_0001, 1'b1, 1, 1'b0, 32'hCAFE_0001, 9};
    vt[4] = '{32'h4000_0100, 1'b1, 3,  1'b0, 32'hDEAD_BEEF, 1'b1, 2, 1'b0, 32'h0,         4};
    vt[5] = '{32'h4000_0200, 1'b0, 2,  1'b1, 32'h5555_AAAA, 1'b1, 2, 1'b1, ERRV,          3};
    vt[6] = '{32'h5000_0000, 1'b0, 1,  1'b0, 32'h0,         1'b0, 0, 1'b1, ERRV,          1};
    vt[7] = '{32'h2000_1000, 1'b0, 1,  1'b0, 32'h1111_0000, 1'b1, 1, 1'b0, 32'h1111_0000, 2};
    vt[8] = '{32'h1FFF_FFFF, 1'b0, 1,  1'b0, 32'h0,         1'b0, 0, 1'b1, ERRV,          1};
    vt[9] = '{32'h2000_0000, 1'b1, 1,  1'b1, 32'h0,         1'b1, 0, 1'b1, ERRV,          2};

    set_fixed_map();
    rst = 1'b1; obi_req = 1'b1; obi_addr = 32'h2000_0000; obi_we = 1'b0; obi_be = '1;
    obi_wdata = '0; reg_rdata = '0; reg_error = '0; reg_ready = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset gnt", 64'(obi_gnt), 64'd0);
    chk("reset rvalid", 64'(obi_rvalid), 64'd0);
    chk("reset valid", 64'(reg_valid), 64'd0);
    chk("reset addr", 64'(reg_addr), 64'd0);
    chk("reset err_count", 64'(err_count), 64'd0);
    rst = 1'b0; obi_req = 1'b0; reg_ready = '0;

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vt[i].addr, vt[i].we, vt[i].lat, vt[i].perr, vt[i].prd,
              1'b0, vt[i].e_hit, vt[i].e_sel, vt[i].e_err, vt[i].e_rd, vt[i].e_k);
    end

    // Overlap: port0 and port2 both cover 0x4000_0000, port0 must win.
    base_a[0] = 32'h4000_0000; end_a[0] = 32'h4000_1000;
    run_txn("overlap", 32'h4000_0000, 1'b0, 2, 1'b0, 32'h0BAD_F00D, 1'b0,
            1'b1, 0, 1'b0, 32'h0BAD_F00D, 3);
    set_fixed_map();

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NP; i++) begin
        base_a[i] = 32'h6000_0000 + ($urandom_range(0, 15) << 12);
        if ($urandom_range(0, 4) == 0) end_a[i] = base_a[i] - 32'h1000;
        else end_a[i] = base_a[i] + ($urandom_range(0, 4) << 12);
      end
      addr = 32'h6000_0000 + $urandom_range(0, 32'h14FFF);
      we   = 1'($urandom);
      lat  = $urandom_range(1, 10);
      perr = ($urandom_range(0, 3) == 0);
      prd  = $urandom;
      model(addr, we, lat, perr, prd, hit, sel, err, rd, k);
      run_txn($sformatf("rnd%0d", n), addr, we, lat, perr, prd, 1'($urandom),
              hit, sel, err, rd, k);
    end
    set_fixed_map();

`ifdef PERIPH_BRIDGE_ERR_COUNT_EN
    chk("err_count", 64'(err_count), 64'(exp_err_cnt));
`else
    chk("err_count", 64'(err_count), 64'd0);
`endif

    // Back-to-back: request held for three reads with immediate ready.
    e_gnt = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    e_rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    nrv = 0;
    @(negedge clk);
    obi_req = 1'b1; obi_addr = 32'h2000_0020; obi_we = 1'b0;
    reg_ready = 4'b0001; reg_error = '0; reg_rdata[0 +: DW] = 32'hA5A5_0001;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) obi_req = 1'b0;
      #1;
      chk($sformatf("b2b gnt c%0d", c), 64'(obi_gnt), 64'(e_gnt[c]));
      chk($sformatf("b2b rvalid c%0d", c), 64'(obi_rvalid), 64'(e_rv[c]));
      if (obi_rvalid) begin
        nrv++;
        chk($sformatf("b2b rdata c%0d", c), 64'(obi_rdata), 64'h0000_0000_A5A5_0001);
      end
    end
    chk("b2b rvalid count", 64'(nrv), 64'd3);
    @(negedge clk);
    reg_ready = '0;

    // Reset in the middle of an access to port1.
    @(negedge clk);
    obi_req = 1'b1; obi_addr = 32'h2000_1010; obi_we = 1'b0;
    #1 chk("rstmid gnt", 64'(obi_gnt), 64'd1);
    repeat (3) @(negedge clk);
    obi_req = 1'b0;
    #1 chk("rstmid valid", 64'(reg_valid), 64'b0010);
    @(negedge clk);
    rst = 1'b1; obi_req = 1'b1;
    #1;
    chk("rstmid gnt_in_reset", 64'(obi_gnt), 64'd0);
    chk("rstmid valid_in_reset", 64'(reg_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0; obi_req = 1'b0; reg_ready = 4'b0010;
    exp_err_cnt = 0;
    #1;
    chk("rstmid valid_after", 64'(reg_valid), 64'd0);
    chk("rstmid addr_after", 64'(reg_addr), 64'd0);
    nrv = 0;
    repeat (12) begin
      @(negedge clk);
      #1 if (obi_rvalid) nrv++;
    end
    chk("rstmid no_response", 64'(nrv), 64'd0);
    chk("rstmid err_count", 64'(err_count), 64'd0);
    reg_ready = '0;
    run_txn("post_reset", 32'h2000_0040, 1'b0, 1, 1'b0, 32'h8765_4321, 1'b0,
            1'b1, 0, 1'b0, 32'h8765_4321, 2);
    run_txn("post_reset_miss", 32'h3000_0000, 1'b1, 1, 1'b0, 32'h0, 1'b0,
            1'b0, 0, 1'b1, ERRV, 1);
`ifdef PERIPH_BRIDGE_ERR_COUNT_EN
    chk("err_count_final", 64'(err_count), 64'(exp_err_cnt));
`else
    chk("err_count_final", 64'(err_count), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
